// File: rtl/ps2_matrix_kbd.sv
// PS/2 keyboard front end: filtered receiver, E0/F0/E1 prefix decoder, programmable keymap RAM
// and a COLS x ROWS key matrix scannable in both directions. Define PS2_ERR_RELEASE_EN to release all keys on frame errors.
module ps2_matrix_kbd #(
    parameter int COLS    = 12,
    parameter int ROWS    = 6,
    parameter int FILTER  = 4,
    parameter int TIMEOUT = 20000,
    localparam int CW     = $clog2(COLS),
    localparam int RW     = $clog2(ROWS),
    localparam int MW     = 1 + CW + RW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ps2_clk,
    input  logic            ps2_dat,
    input  logic            map_we,
    input  logic [8:0]      map_addr,
    input  logic [MW-1:0]   map_data,
    input  logic [ROWS-1:0] row_in,
    output logic [COLS-1:0] col_out,
    input  logic [COLS-1:0] col_in,
    output logic [ROWS-1:0] row_out,
    output logic            key_valid,
    output logic [7:0]      key_code,
    output logic            key_ext,
    output logic            key_break,
    output logic            frame_err,
    output logic [7:0]      pressed_cnt
);

`ifdef PS2_ERR_RELEASE_EN
    localparam bit ERR_REL = 1'b1;
`else
    localparam bit ERR_REL = 1'b0;
`endif

    localparam int FW  = $clog2(FILTER + 1);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam int IW  = $clog2(COLS * ROWS);
    localparam int CW1 = CW + 1;
    localparam int RW1 = RW + 1;
    localparam logic [CW1-1:0] COLS_W = CW1'(COLS);
    localparam logic [RW1-1:0] ROWS_W = RW1'(ROWS);
    localparam logic [IW-1:0]  ROWS_I = IW'(ROWS);

    localparam logic [7:0] B_E0 = 8'hE0;
    localparam logic [7:0] B_F0 = 8'hF0;
    localparam logic [7:0] B_E1 = 8'hE1;
    localparam logic [7:0] B_AA = 8'hAA;
    localparam logic [7:0] B_FA = 8'hFA;

    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_t;

    logic [1:0]       clk_sync, dat_sync;
    logic             filt_clk;
    logic [FW-1:0]    filt_cnt;
    logic             fall;
    logic [10:0]      shreg;
    logic [10:0]      frame;
    logic [3:0]       bit_cnt;
    logic [WDW-1:0]   wd;
    logic             frame_last, frame_good, timeout, err;
    logic             byte_stb;
    logic [7:0]       byte_val;
    state_t           state, state_nx;
    logic [2:0]       pause_cnt, pause_nx;
    logic             lk_go, lk_ext, lk_brk;
    logic [MW-1:0]    keymap [512];
    logic [MW-1:0]    entry;
    logic [COLS*ROWS-1:0] matrix;
    logic             hit;
    logic [IW-1:0]    hit_idx;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            if (clk_sync[1] == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER - 1)) begin
                filt_clk <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    // The filtered clock drops on the FILTER-th consecutive low sample; data is taken in that cycle.
    assign fall       = filt_clk && !clk_sync[1] && (filt_cnt == FW'(FILTER - 1));
    assign frame      = {dat_sync[1], shreg[10:1]};
    assign frame_last = fall && (bit_cnt == 4'd10);
    assign frame_good = !frame[0] && frame[10] && (^frame[9:1]);
    assign timeout    = (bit_cnt != 4'd0) && !fall && (wd == WDW'(TIMEOUT - 1));
    assign err        = (frame_last && !frame_good) || timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            wd        <= '0;
            byte_stb  <= 1'b0;
            byte_val  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err;
            byte_stb  <= frame_last && frame_good;
            if (frame_last) byte_val <= frame[8:1];
            if (fall) begin
                shreg   <= frame;
                wd      <= '0;
                bit_cnt <= frame_last ? 4'd0 : bit_cnt + 4'd1;
            end else if (timeout) begin
                bit_cnt <= '0;
                wd      <= '0;
            end else if (bit_cnt != 4'd0) begin
                wd <= wd + WDW'(1);
            end else begin
                wd <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            pause_cnt <= '0;
        end else begin
            state     <= state_nx;
            pause_cnt <= pause_nx;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        pause_nx = pause_cnt;
        lk_go    = 1'b0;
        lk_ext   = 1'b0;
        lk_brk   = 1'b0;
        if (ERR_REL && err) begin
            state_nx = S_IDLE;
        end else if (byte_stb) begin
            case (state)
                S_IDLE: begin
                    if (byte_val == B_E0) state_nx = S_EXT;
                    else if (byte_val == B_F0) state_nx = S_BRK;
                    else if (byte_val == B_E1) begin
                        state_nx = S_PAUSE;
                        pause_nx = '0;
                    end else if (byte_val != B_AA && byte_val != B_FA) lk_go = 1'b1;
                end
                S_EXT: begin
                    if (byte_val == B_F0) state_nx = S_EXT_BRK;
                    else begin
                        lk_go    = 1'b1;
                        lk_ext   = 1'b1;
                        state_nx = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (byte_val == B_E0) state_nx = S_EXT_BRK;
                    else begin
                        lk_go    = 1'b1;
                        lk_brk   = 1'b1;
                        state_nx = S_IDLE;
                    end
                end
                S_EXT_BRK: begin
                    lk_go    = 1'b1;
                    lk_ext   = 1'b1;
                    lk_brk   = 1'b1;
                    state_nx = S_IDLE;
                end
                S_PAUSE: begin
                    if (pause_cnt == 3'd6) state_nx = S_IDLE;
                    else pause_nx = pause_cnt + 3'd1;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // NOTE: the keymap and its read register have no reset so they map onto block RAM; read-before-write.
    always_ff @(posedge clk) begin
        if (lk_go) entry <= keymap[{lk_ext, byte_val}];
        if (map_we) keymap[map_addr] <= map_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_valid <= 1'b0;
            key_code  <= '0;
            key_ext   <= 1'b0;
            key_break <= 1'b0;
        end else begin
            key_valid <= lk_go;
            if (lk_go) begin
                key_code  <= byte_val;
                key_ext   <= lk_ext;
                key_break <= lk_brk;
            end
        end
    end

    assign hit     = key_valid && entry[MW-1]
                     && ({1'b0, entry[RW +: CW]} < COLS_W)
                     && ({1'b0, entry[RW-1:0]} < ROWS_W);
    assign hit_idx = IW'(entry[RW +: CW]) * ROWS_I + IW'(entry[RW-1:0]);

    // Count follows actual bit transitions, so repeats and releases of idle keys leave it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            matrix      <= '0;
            pressed_cnt <= '0;
        end else if (ERR_REL && err) begin
            matrix      <= '0;
            pressed_cnt <= '0;
        end else if (hit) begin
            if (!key_break && !matrix[hit_idx]) begin
                matrix[hit_idx] <= 1'b1;
                pressed_cnt     <= pressed_cnt + 8'd1;
            end else if (key_break && matrix[hit_idx]) begin
                matrix[hit_idx] <= 1'b0;
                pressed_cnt     <= pressed_cnt - 8'd1;
            end
        end
    end

    always_comb begin
        col_out = '1;
        row_out = '1;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (matrix[c*ROWS + r] && !row_in[r]) col_out[c] = 1'b0;
                if (matrix[c*ROWS + r] && !col_in[c]) row_out[r] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_matrix_kbd.sv
// Self-checking bench for ps2_matrix_kbd: directed vector table, multi-cycle corner sequences,
// and randomized byte streams against a behavioural keyboard model.
module tb_ps2_matrix_kbd;

    localparam int COLS    = 12;
    localparam int ROWS    = 6;
    localparam int FILTER  = 4;
    localparam int TIMEOUT = 400;
    localparam int MW      = 8;

`ifdef PS2_ERR_RELEASE_EN
    localparam bit ERR_REL = 1'b1;
`else
    localparam bit ERR_REL = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            ps2_clk = 1'b1;
    logic            ps2_dat = 1'b1;
    logic            map_we = 1'b0;
    logic [8:0]      map_addr = '0;
    logic [MW-1:0]   map_data = '0;
    logic [ROWS-1:0] row_in = '0;
    logic [COLS-1:0] col_out;
    logic [COLS-1:0] col_in = '0;
    logic [ROWS-1:0] row_out;
    logic            key_valid;
    logic [7:0]      key_code;
    logic            key_ext;
    logic            key_break;
    logic            frame_err;
    logic [7:0]      pressed_cnt;

    ps2_matrix_kbd #(.COLS(COLS), .ROWS(ROWS), .FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .map_we(map_we), .map_addr(map_addr), .map_data(map_data),
        .row_in(row_in), .col_out(col_out), .col_in(col_in), .row_out(row_out),
        .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
        .frame_err(frame_err), .pressed_cnt(pressed_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Event monitor: every high cycle of a pulse is recorded, so stretched pulses show up as extras.
    logic [9:0] got_q[$];
    int err_seen = 0;
    always @(negedge clk) begin
        if (key_valid === 1'b1) got_q.push_back({key_ext, key_break, key_code});
        if (frame_err === 1'b1) err_seen++;
    end

    // Behavioural keyboard model.
    bit            m_mat [COLS][ROWS];
    logic [MW-1:0] km [512];
    bit            m_ext, m_brk;
    int            m_pause;
    logic [9:0]    exp_q[$];
    int            exp_err = 0;

    function automatic int m_count();
        int n = 0;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                n += int'(m_mat[c][r]);
        return n;
    endfunction

    task automatic model_error();
        exp_err++;
        if (ERR_REL) begin
            for (int c = 0; c < COLS; c++)
                for (int r = 0; r < ROWS; r++)
                    m_mat[c][r] = 1'b0;
            m_ext = 1'b0; m_brk = 1'b0; m_pause = 0;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input bit bad);
        logic [MW-1:0] e;
        int col, row;
        if (bad) begin
            model_error();
            return;
        end
        if (m_pause > 0) begin
            m_pause--;
            return;
        end
        if (!m_ext && !m_brk) begin
            if (b == 8'hE1) begin m_pause = 7; return; end
            if (b == 8'hAA || b == 8'hFA) return;
        end
        if (b == 8'hE0 && !m_ext) begin m_ext = 1'b1; return; end
        if (b == 8'hF0 && !m_brk) begin m_brk = 1'b1; return; end
        exp_q.push_back({m_ext, m_brk, b});
        e = km[{m_ext, b}];
        col = int'(e[6:3]);
        row = int'(e[2:0]);
        if (e[7] && col < COLS && row < ROWS) m_mat[col][row] = !m_brk;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic ps2_bit(input logic d);
        ps2_dat = d;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad);
        logic [10:0] w;
        w = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(w[i]);
    endtask

    task automatic do_frame(input logic [7:0] b, input bit bad);
        send_frame(b, bad);
        model_byte(b, bad);
        repeat (15) @(negedge clk);
    endtask

    task automatic map_write(input logic [8:0] a, input logic [MW-1:0] d);
        @(negedge clk);
        map_we = 1'b1; map_addr = a; map_data = d;
        @(negedge clk);
        map_we = 1'b0;
        km[a] = d;
    endtask

    task automatic check_events(input string tag);
        logic [9:0] g, e;
        check({tag, "_event_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_event"}, g, e);
        end
        got_q.delete();
        exp_q.delete();
        check({tag, "_frame_err_total"}, err_seen, exp_err);
        check({tag, "_pressed_cnt"}, pressed_cnt, m_count());
    endtask

    task automatic check_scan(input string tag);
        logic [COLS-1:0] ec;
        logic [ROWS-1:0] er;
        logic [ROWS-1:0] rone;
        logic [COLS-1:0] cone;
        rone = 1;
        cone = 1;
        for (int r = 0; r < ROWS; r++) begin
            row_in = ~(rone << r);
            #1;
            ec = '1;
            for (int c = 0; c < COLS; c++) if (m_mat[c][r]) ec[c] = 1'b0;
            check({tag, "_col_out"}, col_out, ec);
        end
        row_in = '1;
        for (int c = 0; c < COLS; c++) begin
            col_in = ~(cone << c);
            #1;
            er = '1;
            for (int r = 0; r < ROWS; r++) if (m_mat[c][r]) er[r] = 1'b0;
            check({tag, "_row_out"}, row_out, er);
        end
        col_in = '1;
    endtask

    typedef struct {
        logic [7:0]  b;
        bit          bad;
        bit          ev;
        bit          ext;
        bit          brk;
        int          cnt;
        logic [11:0] col;
        bit          err;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] b, input bit bad, input bit ev, input bit ext,
                                input bit brk, input int cnt, input logic [11:0] col, input bit err);
        vec_t v;
        v.b = b; v.bad = bad; v.ev = ev; v.ext = ext; v.brk = brk;
        v.cnt = cnt; v.col = col; v.err = err;
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t tbl[22];
        int   e0;
        int   held_cnt;
        logic [11:0] held_col;
        logic [9:0]  g;
        bit   seen;
        logic [7:0] pool[6];

        m_ext = 1'b0; m_brk = 1'b0; m_pause = 0;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                m_mat[c][r] = 1'b0;

        // Reset state with every row and column selected.
        repeat (3) @(negedge clk);
        check("reset_col_out", col_out, {COLS{1'b1}});
        check("reset_row_out", row_out, {ROWS{1'b1}});
        check("reset_pressed_cnt", pressed_cnt, 0);
        reset = 1'b1;
        repeat (60) @(negedge clk);
        check("idle_col_out", col_out, {COLS{1'b1}});
        check("idle_row_out", row_out, {ROWS{1'b1}});
        check("idle_no_key_valid", got_q.size(), 0);
        check("idle_no_frame_err", err_seen, 0);
        row_in = '1;
        col_in = '1;

        @(negedge clk);
        map_we = 1'b1;
        for (int a = 0; a < 512; a++) begin
            map_addr = 9'(a);
            map_data = '0;
            km[a] = '0;
            @(negedge clk);
        end
        map_we = 1'b0;
        map_write(9'h01C, 8'hC0);
        map_write(9'h174, 8'h90);

        held_cnt = ERR_REL ? 0 : 1;
        held_col = ERR_REL ? 12'hFFF : 12'hEFF;
        tbl[0]  = mk(8'h1C, 0, 1, 0, 0, 1, 12'hEFF, 0);
        tbl[1]  = mk(8'hF0, 0, 0, 0, 0, 1, 12'hEFF, 0);
        tbl[2]  = mk(8'h1C, 0, 1, 0, 1, 0, 12'hFFF, 0);
        tbl[3]  = mk(8'hE0, 0, 0, 0, 0, 0, 12'hFFF, 0);
        tbl[4]  = mk(8'h74, 0, 1, 1, 0, 1, 12'hFFB, 0);
        tbl[5]  = mk(8'hE0, 0, 0, 0, 0, 1, 12'hFFB, 0);
        tbl[6]  = mk(8'h74, 0, 1, 1, 0, 1, 12'hFFB, 0);
        tbl[7]  = mk(8'hE0, 0, 0, 0, 0, 1, 12'hFFB, 0);
        tbl[8]  = mk(8'hF0, 0, 0, 0, 0, 1, 12'hFFB, 0);
        tbl[9]  = mk(8'h74, 0, 1, 1, 1, 0, 12'hFFF, 0);
        tbl[10] = mk(8'hE1, 0, 0, 0, 0, 0, 12'hFFF, 0);
        tbl[11] = mk(8'h14, 0, 0, 0, 0, 0, 12'hFFF, 0);
        tbl[12] = mk(8'h77, 0, 0, 0, 0, 0, 12'hFFF, 0);
        tbl[13] = mk(8'hE1, 0, 0, 0, 0, 0, 12'hFFF, 0);
        tbl[14] = mk(8'hF0, 0, 0, 0, 0, 0, 12'hFFF, 0);
        tbl[15] = mk(8'h14, 0, 0, 0, 0, 0, 12'hFFF, 0);
        tbl[16] = mk(8'hF0, 0, 0, 0, 0, 0, 12'hFFF, 0);
        tbl[17] = mk(8'h77, 0, 0, 0, 0, 0, 12'hFFF, 0);
        tbl[18] = mk(8'h1C, 0, 1, 0, 0, 1, 12'hEFF, 0);
        tbl[19] = mk(8'h1C, 1, 0, 0, 0, held_cnt, held_col, 1);
        tbl[20] = mk(8'hF0, 0, 0, 0, 0, held_cnt, held_col, 0);
        tbl[21] = mk(8'h1C, 0, 1, 0, 1, 0, 12'hFFF, 0);

        for (int i = 0; i < 22; i++) begin
            e0 = err_seen;
            got_q.delete();
            do_frame(tbl[i].b, tbl[i].bad);
            exp_q.delete();
            check($sformatf("tbl%0d_event_count", i), got_q.size(), tbl[i].ev ? 1 : 0);
            if (got_q.size() > 0) begin
                g = got_q.pop_front();
                check($sformatf("tbl%0d_event", i), g, {tbl[i].ext, tbl[i].brk, tbl[i].b});
            end
            got_q.delete();
            check($sformatf("tbl%0d_pressed_cnt", i), pressed_cnt, tbl[i].cnt);
            check($sformatf("tbl%0d_frame_err", i), err_seen - e0, tbl[i].err ? 1 : 0);
            row_in = 6'b111110;
            #1;
            check($sformatf("tbl%0d_col_out_row0", i), col_out, tbl[i].col);
            row_in = '1;
        end
        check_scan("after_table");

        // Glitch one cycle short of FILTER: must not shift a bit.
        @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FILTER - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (30) @(negedge clk);
        do_frame(8'h1C, 1'b0);
        check_events("after_short_glitch");
        do_frame(8'hF0, 1'b0);
        do_frame(8'h1C, 1'b0);
        check_events("release_after_glitch");

        // A FILTER-wide pulse is a real edge: one stray bit, later aborted by the watchdog.
        do_frame(8'h1C, 1'b0);
        @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FILTER) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (TIMEOUT + 60) @(negedge clk);
        model_error();
        check_events("full_width_pulse_timeout");
        check("pulse_timeout_held_cnt", pressed_cnt, ERR_REL ? 0 : 1);

        // Partial frame of 5 bits, then idle past the watchdog.
        do_frame(8'h1C, 1'b0);
        ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
        repeat (TIMEOUT + 60) @(negedge clk);
        model_error();
        check_events("partial_frame_timeout");
        check_scan("partial_frame_timeout");
        do_frame(8'hF0, 1'b0);
        do_frame(8'h1C, 1'b0);
        check_events("decode_after_timeout");
        check("timeout_release_cnt", pressed_cnt, 0);

        // Keymap write landing in the lookup cycle: the old entry wins.
        fork
            send_frame(8'h1C, 1'b0);
            begin
                seen = 1'b0;
                for (int k = 0; k < 400 && !seen; k++) begin
                    @(negedge clk);
                    if (dut.lk_go === 1'b1) begin
                        seen = 1'b1;
                        map_we = 1'b1; map_addr = 9'h01C; map_data = 8'hA9;
                        @(negedge clk);
                        map_we = 1'b0;
                    end
                end
                check("collision_lookup_seen", seen, 1);
            end
        join
        model_byte(8'h1C, 1'b0);
        km[9'h01C] = 8'hA9;
        repeat (15) @(negedge clk);
        check_events("collision_old_entry");
        check_scan("collision_old_entry");
        do_frame(8'hF0, 1'b0);
        do_frame(8'h1C, 1'b0);
        check_events("new_entry_release");
        check("held_key_kept_cnt", pressed_cnt, 1);
        do_frame(8'h1C, 1'b0);
        check_events("new_entry_press");
        check("new_entry_press_cnt", pressed_cnt, 2);
        check_scan("new_entry_press");

        // Random keymap (including invalid and out-of-range entries), then random byte streams.
        @(negedge clk);
        map_we = 1'b1;
        for (int a = 0; a < 512; a++) begin
            map_addr = 9'(a);
            map_data = {($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                        4'($urandom_range(0, 15)), 3'($urandom_range(0, 7))};
            km[a] = map_data;
            @(negedge clk);
        end
        map_we = 1'b0;

        pool[0] = 8'h1C; pool[1] = 8'h74; pool[2] = 8'h15;
        pool[3] = 8'h23; pool[4] = 8'h2B; pool[5] = 8'h5A;
        for (int n = 0; n < 100; n++) begin
            int sel;
            logic [7:0] b;
            bit bad;
            sel = int'($urandom_range(0, 15));
            if (sel < 6)        b = pool[sel];
            else if (sel < 9)   b = 8'hE0;
            else if (sel < 12)  b = 8'hF0;
            else if (sel == 12) b = 8'hE1;
            else if (sel == 13) b = 8'hAA;
            else if (sel == 14) b = 8'hFA;
            else                b = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 11) == 0);
            do_frame(b, bad);
            check_events($sformatf("rand%0d", n));
            if (n % 10 == 9) check_scan($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
